// File: rtl/ines_loader.sv
// iNES cartridge image loader.
// Accepts an image one byte at a time, validates and parses the 16-byte
// header, skips an optional 512-byte trainer, then streams the PRG and CHR
// payloads into their ROM memories as single-cycle write strobes. Exposes
// the mapper configuration (mapper number, last PRG bank, mirroring, CHR-RAM)
// and raises done on a complete load or error on a rejected header.
// Optional feature: define INES_NES2_EN to reject NES 2.0 headers that carry
// mapper bits above 7 or PRG/CHR count MSBs.
module ines_loader #(
    parameter int PRG_MAX_BANKS = 16,
    parameter int CHR_MAX_BANKS = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [17:0] prg_a,
    output logic [16:0] chr_a,
    output logic [7:0]  mem_d,
    output logic        prg_w,
    output logic        chr_w,
    output logic [7:0]  mapper_num,
    output logic [3:0]  mapper_max,
    output logic        mirror_v,
    output logic        chr_ram,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_HDR,
        S_TRAIN,
        S_PRG,
        S_CHR,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state;
    logic [3:0]  hdr_idx;
    logic [8:0]  train_cnt;
    logic [17:0] offset;
    logic [7:0]  prg_cnt;
    logic [7:0]  chr_cnt;
    logic        trainer;
`ifdef INES_NES2_EN
    logic        nes2;
    logic        nes2_bad;
`endif

    logic        accept;
    logic [7:0]  magic_byte;
    logic        hdr_bad;
    logic [3:0]  chr_max;
    logic [17:0] prg_last;
    logic [16:0] chr_last;

    assign in_ready = (state != S_DONE) && (state != S_ERR);
    assign accept   = in_valid && in_ready;

    // Last payload offsets: a bank count of 16 becomes index 15 after the
    // 4-bit decrement, so the full 256 KB / 128 KB ranges end exactly at the
    // top address without the offset counter having to wrap.
    assign chr_max  = chr_cnt[3:0] - 4'd1;
    assign prg_last = {mapper_max, 14'h3FFF};
    assign chr_last = {chr_max, 13'h1FFF};

    // Header sanity: at least one PRG bank, and both counts within capacity.
`ifdef INES_NES2_EN
    assign hdr_bad = (prg_cnt == 8'd0)
                  || ({24'd0, prg_cnt} > PRG_MAX_BANKS)
                  || ({24'd0, chr_cnt} > CHR_MAX_BANKS)
                  || nes2_bad;
`else
    assign hdr_bad = (prg_cnt == 8'd0)
                  || ({24'd0, prg_cnt} > PRG_MAX_BANKS)
                  || ({24'd0, chr_cnt} > CHR_MAX_BANKS);
`endif

    // Expected "NES<EOF>" signature byte for header positions 0..3.
    always_comb begin
        magic_byte = 8'h4E;
        case (hdr_idx[1:0])
            2'd0: magic_byte = 8'h4E;
            2'd1: magic_byte = 8'h45;
            2'd2: magic_byte = 8'h53;
            2'd3: magic_byte = 8'h1A;
            default: magic_byte = 8'h4E;
        endcase
    end

    // Load sequencer: header parse, trainer skip, PRG/CHR writes, terminal states.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= S_HDR;
            hdr_idx    <= 4'd0;
            train_cnt  <= 9'd0;
            offset     <= 18'd0;
            prg_cnt    <= 8'd0;
            chr_cnt    <= 8'd0;
            trainer    <= 1'b0;
            prg_a      <= 18'd0;
            chr_a      <= 17'd0;
            mem_d      <= 8'd0;
            prg_w      <= 1'b0;
            chr_w      <= 1'b0;
            mapper_num <= 8'd0;
            mapper_max <= 4'd0;
            mirror_v   <= 1'b0;
            chr_ram    <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef INES_NES2_EN
            nes2       <= 1'b0;
            nes2_bad   <= 1'b0;
`endif
        end else begin
            prg_w <= 1'b0;
            chr_w <= 1'b0;
            case (state)
                S_HDR: begin
                    if (accept) begin
                        hdr_idx <= hdr_idx + 4'd1;
                        if (hdr_idx < 4'd4 && in_data != magic_byte) begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end
                        case (hdr_idx)
                            4'd4: prg_cnt <= in_data;
                            4'd5: chr_cnt <= in_data;
                            4'd6: begin
                                mirror_v        <= in_data[0];
                                trainer         <= in_data[2];
                                mapper_num[3:0] <= in_data[7:4];
                            end
                            4'd7: begin
                                mapper_num[7:4] <= in_data[7:4];
`ifdef INES_NES2_EN
                                nes2            <= (in_data[3:2] == 2'b10);
`endif
                            end
`ifdef INES_NES2_EN
                            4'd8: if (nes2 && in_data[3:0] != 4'd0) nes2_bad <= 1'b1;
                            4'd9: if (nes2 && in_data != 8'd0) nes2_bad <= 1'b1;
`endif
                            4'd15: begin
                                mapper_max <= prg_cnt[3:0] - 4'd1;
                                if (hdr_bad) begin
                                    state <= S_ERR;
                                    error <= 1'b1;
                                end else begin
                                    state <= trainer ? S_TRAIN : S_PRG;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_TRAIN: begin
                    if (accept) begin
                        train_cnt <= train_cnt + 9'd1;
                        if (train_cnt == 9'd511) state <= S_PRG;
                    end
                end
                S_PRG: begin
                    if (accept) begin
                        prg_w <= 1'b1;
                        prg_a <= offset;
                        mem_d <= in_data;
                        if (offset == prg_last) begin
                            offset <= 18'd0;
                            if (chr_cnt == 8'd0) begin
                                chr_ram <= 1'b1;
                                done    <= 1'b1;
                                state   <= S_DONE;
                            end else begin
                                state <= S_CHR;
                            end
                        end else begin
                            offset <= offset + 18'd1;
                        end
                    end
                end
                S_CHR: begin
                    if (accept) begin
                        chr_w <= 1'b1;
                        chr_a <= offset[16:0];
                        mem_d <= in_data;
                        if (offset[16:0] == chr_last) begin
                            offset <= 18'd0;
                            done   <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            offset <= offset + 18'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ines_loader.sv
// Scoreboard bench for ines_loader: the driver pushes the expected PRG/CHR
// write for every payload byte it hands over, and a monitor pops and compares
// each strobe the loader produces.
module tb_ines_loader;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [17:0] prg_a;
    logic [16:0] chr_a;
    logic [7:0]  mem_d;
    logic        prg_w;
    logic        chr_w;
    logic [7:0]  mapper_num;
    logic [3:0]  mapper_max;
    logic        mirror_v;
    logic        chr_ram;
    logic        done;
    logic        error;

    ines_loader dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .prg_a      (prg_a),
        .chr_a      (chr_a),
        .mem_d      (mem_d),
        .prg_w      (prg_w),
        .chr_w      (chr_w),
        .mapper_num (mapper_num),
        .mapper_max (mapper_max),
        .mirror_v   (mirror_v),
        .chr_ram    (chr_ram),
        .done       (done),
        .error      (error)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        is_chr;
        logic [17:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expected write.
    always @(negedge clock) begin
        if (prg_w || chr_w) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=prg_w:%0b chr_w:%0b prg_a:%0h chr_a:%0h d:%0h required=no write",
                         prg_w, chr_w, prg_a, chr_a, mem_d);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write", {4'd0, prg_w, chr_w, (chr_w ? {1'b0, chr_a} : prg_a), mem_d},
                             {4'd0, !e.is_chr, e.is_chr, e.addr, e.data});
            end
        end
    end

    function automatic logic [7:0] pat(input int i, input int seed);
        return 8'((i * 13) ^ (i >> 8) ^ seed);
    endfunction

    task automatic mk_hdr(output logic [7:0] h [16], input logic [7:0] b4, input logic [7:0] b5,
                          input logic [7:0] b6, input logic [7:0] b7);
        for (int i = 0; i < 16; i++) h[i] = 8'd0;
        h[0] = 8'h4E; h[1] = 8'h45; h[2] = 8'h53; h[3] = 8'h1A;
        h[4] = b4; h[5] = b5; h[6] = b6; h[7] = b7;
    endtask

    // Present one byte; returns just after the clock edge that accepts it.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int g;
        g = 0;
        if (gaps && $urandom_range(0, 3) == 0) g = $urandom_range(1, 3);
        repeat (g) begin
            @(negedge clock);
            in_valid = 1'b0;
        end
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = b;
        if (!in_ready) chk("in_ready_during_load", in_ready, 1);
        @(posedge clock);
    endtask

    task automatic idle();
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_strobes", {prg_w, chr_w}, 0);
        chk("rst_mapper_num", mapper_num, 0);
        chk("rst_mapper_max", mapper_max, 0);
        chk("rst_mirror_chrram", {mirror_v, chr_ram}, 0);
        chk("rst_queue_empty", exp_q.size(), 0);
        exp_q.delete();
        reset_n = 1'b1;
    endtask

    // Full image: header, optional trainer, PRG and CHR payload; stop_at >= 0
    // abandons the PRG payload before that byte is sent.
    task automatic load(input logic [7:0] h [16], input int prg_n, input int chr_n,
                        input bit trn, input bit gaps, input int stop_at, input int seed);
        wr_t w;
        for (int i = 0; i < 16; i++) send_byte(h[i], gaps);
        if (trn) for (int i = 0; i < 512; i++) send_byte(8'hA5 ^ 8'(i), gaps);
        for (int i = 0; i < prg_n * 16384; i++) begin
            if (stop_at >= 0 && i == stop_at) begin
                idle();
                return;
            end
            send_byte(pat(i, seed), gaps);
            w.is_chr = 1'b0; w.addr = 18'(i); w.data = pat(i, seed);
            exp_q.push_back(w);
        end
        for (int i = 0; i < chr_n * 8192; i++) begin
            send_byte(pat(i, seed + 77), gaps);
            w.is_chr = 1'b1; w.addr = 18'(i); w.data = pat(i, seed + 77);
            exp_q.push_back(w);
        end
        idle();
    endtask

    task automatic check_final(input string name, input logic [7:0] mnum, input logic [3:0] mmax,
                               input logic mir, input logic cram);
        repeat (3) @(negedge clock);
        chk({name, "_done"}, done, 1);
        chk({name, "_error"}, error, 0);
        chk({name, "_in_ready"}, in_ready, 0);
        chk({name, "_mapper_num"}, mapper_num, mnum);
        chk({name, "_mapper_max"}, mapper_max, mmax);
        chk({name, "_mirror_v"}, mirror_v, mir);
        chk({name, "_chr_ram"}, chr_ram, cram);
        chk({name, "_all_writes_seen"}, exp_q.size(), 0);
        // Trailing bytes must be refused and produce no strobes.
        in_valid = 1'b1;
        in_data  = 8'hFF;
        repeat (4) begin
            @(negedge clock);
            chk({name, "_trailing_refused"}, in_ready, 0);
        end
        in_valid = 1'b0;
        chk({name, "_done_held"}, {done, error}, 2'b10);
        $display("image %s: mapper=%0h max=%0h mirror=%0b chr_ram=%0b", name, mapper_num, mapper_max, mirror_v, chr_ram);
    endtask

    // Header-only run that should end (or not) in the error state after byte 15.
    task automatic hdr_only(input string name, input logic [7:0] h [16], input bit exp_err);
        for (int i = 0; i < 16; i++) send_byte(h[i], 1'b0);
        idle();
        chk({name, "_error"}, error, exp_err);
        chk({name, "_in_ready"}, in_ready, !exp_err);
        chk({name, "_done"}, done, 0);
        $display("header %s: error=%0b", name, error);
        do_reset();
    endtask

    initial begin
        logic [7:0] h [16];

        // Reset state
        repeat (3) @(negedge clock);
        chk("por_in_ready", in_ready, 1);
        chk("por_outputs", {done, error, prg_w, chr_w, mirror_v, chr_ram}, 0);
        chk("por_mapper", {mapper_num, mapper_max}, 0);
        reset_n = 1'b1;

        // NROM: 16 KB PRG, 8 KB CHR, vertical mirroring
        mk_hdr(h, 8'h01, 8'h01, 8'h01, 8'h00);
        load(h, 1, 1, 1'b0, 1'b0, -1, 8'h11);
        check_final("nrom", 8'h00, 4'd0, 1'b1, 1'b0);
        do_reset();

        // Trainer: 512 bytes skipped, the 529th byte lands at prg_a 0
        mk_hdr(h, 8'h01, 8'h00, 8'h04, 8'h00);
        load(h, 1, 0, 1'b1, 1'b0, 4, 8'h22);
        repeat (2) @(negedge clock);
        chk("trainer_writes_seen", exp_q.size(), 0);
        chk("trainer_not_done", done, 0);
        $display("image trainer: first PRG writes after 512 skipped bytes");
        do_reset();

        // Bad signature at byte 2: error immediately, nothing accepted afterwards
        mk_hdr(h, 8'h01, 8'h01, 8'h00, 8'h00);
        h[2] = 8'h54;
        for (int i = 0; i < 3; i++) send_byte(h[i], 1'b0);
        idle();
        chk("badmagic_error", error, 1);
        chk("badmagic_in_ready", in_ready, 0);
        chk("badmagic_done", done, 0);
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("badmagic_refused", in_ready, 0);
        end
        in_valid = 1'b0;
        $display("header badmagic: error=%0b", error);
        do_reset();

        mk_hdr(h, 8'd17, 8'h01, 8'h00, 8'h00);
        hdr_only("prg17", h, 1'b1);
        mk_hdr(h, 8'd0, 8'h01, 8'h00, 8'h00);
        hdr_only("prg0", h, 1'b1);
        mk_hdr(h, 8'd1, 8'd17, 8'h00, 8'h00);
        hdr_only("chr17", h, 1'b1);
        mk_hdr(h, 8'd16, 8'd16, 8'h00, 8'h00);
        hdr_only("max_counts", h, 1'b0);

        // NES 2.0 header carrying mapper bits 11:8
        mk_hdr(h, 8'h01, 8'h00, 8'h00, 8'h08);
        h[8] = 8'h01;
`ifdef INES_NES2_EN
        hdr_only("nes2_ext", h, 1'b1);
`else
        hdr_only("nes2_ext", h, 1'b0);
`endif

        // UxROM-style, 2 PRG banks, CHR-RAM: aborted by reset at PRG byte 1000,
        // then reloaded from a fresh header, both with random in_valid gaps
        mk_hdr(h, 8'h02, 8'h00, 8'h20, 8'h00);
        load(h, 2, 0, 1'b0, 1'b1, 1000, 8'h33);
        do_reset();
        load(h, 2, 0, 1'b0, 1'b1, -1, 8'h33);
        check_final("uxrom", 8'h02, 4'd1, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
